// File: rtl/uart_tx_param_pkg.sv
// Shared definitions for the parametrised UART transmitter and matching receiver.
// Includes state encodings, parity mode constants and the parity helper.
package uart_tx_param_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } uart_state_e;

  localparam int unsigned PAR_NONE      = 0;
  localparam int unsigned PAR_ODD       = 1;
  localparam int unsigned PAR_EVEN      = 2;
  localparam int unsigned MAX_DATA_BITS = 9;

  // Zero padding above the payload leaves the XOR reduction unchanged.
  function automatic logic calc_parity(input logic [MAX_DATA_BITS-1:0] data,
                                       input int unsigned mode);
    return (mode == PAR_ODD) ? ~(^data) : ^data;
  endfunction

endpackage

// File: rtl/uart_baud_counter.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 and flags the last clock of each bit.
// bit_end is registered and is high during the cycle the count sits at its terminal value.
module uart_baud_counter #(
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  output logic bit_end
);

  localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_inc;

  assign cnt_inc = cnt_q + CNT_W'(1);

  // Look one count ahead so the flag lines up with the terminal count.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q   <= '0;
      bit_end <= 1'b0;
    end else if (clear) begin
      cnt_q   <= '0;
      bit_end <= 1'b0;
    end else if (cnt_q == CNT_W'(CLKS_PER_BIT - 1)) begin
      cnt_q   <= '0;
      bit_end <= 1'b0;
    end else begin
      cnt_q   <= cnt_inc;
      bit_end <= (cnt_inc == CNT_W'(CLKS_PER_BIT - 1));
    end
  end

endmodule

// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter: configurable data width, parity and stop bits,
// valid/ready frame acceptance and a registered serial line output.
module uart_tx_param
  import uart_tx_param_pkg::*;
#(
  parameter int unsigned DATA_BITS = 8,
  parameter int unsigned PARITY    = 0,
  parameter int unsigned STOP_BITS = 1,
  parameter int unsigned CLK_FREQ  = 100000000,
  parameter int unsigned BAUD      = 9600
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  input  logic [DATA_BITS-1:0] tx_data,
  output logic                 tx,
  output logic                 busy,
  output logic                 tx_done
);

  localparam int unsigned CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int unsigned BIT_W        = $clog2(DATA_BITS);
  localparam bit          HAS_PARITY   = (PARITY != PAR_NONE);

  if ((DATA_BITS < 5) || (DATA_BITS > 9) || (STOP_BITS < 1) || (STOP_BITS > 2) ||
      (PARITY > PAR_EVEN) || (CLKS_PER_BIT < 2)) begin : g_param_check
    $error("uart_tx_param: illegal parameter combination");
  end

  uart_state_e          state_q, state_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [BIT_W-1:0]     bit_cnt_q, bit_cnt_d;
  logic                 stop_cnt_q, stop_cnt_d;
  logic                 par_q, par_d;
  logic                 tx_q, tx_d;
  logic                 busy_q, busy_d;
  logic                 ready_q, ready_d;
  logic                 accept;
  logic                 bit_end;
  logic                 last_stop;

  assign accept    = tx_valid & ready_q;
  assign last_stop = (stop_cnt_q == 1'(STOP_BITS - 1));

  uart_baud_counter #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk    (clk),
    .reset_n(reset_n),
    .clear  (accept),
    .bit_end(bit_end)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      shift_q    <= '0;
      bit_cnt_q  <= '0;
      stop_cnt_q <= 1'b0;
      par_q      <= 1'b0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
      ready_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      bit_cnt_q  <= bit_cnt_d;
      stop_cnt_q <= stop_cnt_d;
      par_q      <= par_d;
      tx_q       <= tx_d;
      busy_q     <= busy_d;
      ready_q    <= ready_d;
    end
  end

  // Next-state logic; tx_d is the line level for the state being entered.
  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    bit_cnt_d  = bit_cnt_q;
    stop_cnt_d = stop_cnt_q;
    par_d      = par_q;
    tx_d       = tx_q;
    busy_d     = busy_q;
    unique case (state_q)
      S_IDLE: begin
        tx_d   = 1'b1;
        busy_d = 1'b0;
        if (accept) begin
          state_d    = S_START;
          shift_d    = tx_data;
          par_d      = calc_parity(MAX_DATA_BITS'(tx_data), PARITY);
          bit_cnt_d  = '0;
          stop_cnt_d = 1'b0;
          tx_d       = 1'b0;
          busy_d     = 1'b1;
        end
      end
      S_START: begin
        if (bit_end) begin
          state_d = S_DATA;
          tx_d    = shift_q[0];
        end
      end
      S_DATA: begin
        if (bit_end) begin
          shift_d = {1'b0, shift_q[DATA_BITS-1:1]};
          if (bit_cnt_q == BIT_W'(DATA_BITS - 1)) begin
            if (HAS_PARITY) begin
              state_d = S_PARITY;
              tx_d    = par_q;
            end else begin
              state_d = S_STOP;
              tx_d    = 1'b1;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + BIT_W'(1);
            tx_d      = shift_d[0];
          end
        end
      end
      S_PARITY: begin
        if (bit_end) begin
          state_d = S_STOP;
          tx_d    = 1'b1;
        end
      end
      S_STOP: begin
        if (bit_end) begin
          if (last_stop) begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
          end else begin
            stop_cnt_d = 1'b1;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        tx_d    = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
    ready_d = (state_d == S_IDLE);
  end

  assign tx       = tx_q;
  assign busy     = busy_q;
  assign tx_ready = ready_q;
  // Decoded from flops only: high on the last clock of the final stop bit.
  assign tx_done  = (state_q == S_STOP) & bit_end & last_stop;

endmodule

// File: tb/tb_uart_tx_param.sv
// Directed and random-data bench for uart_tx_param at 16 clocks per bit,
// covering 8N1, 8E1, 8O1 and 7N2 instances selected through a shared index.
module tb_uart_tx_param;

  localparam int CPB = 16;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [3:0] valid_v;
  logic [7:0] data;
  logic [3:0] ready_v, tx_v, busy_v, done_v;
  logic [1:0] sel;
  int         checks = 0;
  int         errors = 0;

  int nb_cfg [4] = '{8, 8, 8, 7};
  int par_cfg[4] = '{0, 2, 1, 0};
  int st_cfg [4] = '{1, 1, 1, 2};

  always #5 clk = ~clk;

  uart_tx_param #(.DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .CLK_FREQ(1600), .BAUD(100)) u_8n1 (
    .clk(clk), .reset_n(reset_n), .tx_valid(valid_v[0]), .tx_ready(ready_v[0]),
    .tx_data(data[7:0]), .tx(tx_v[0]), .busy(busy_v[0]), .tx_done(done_v[0]));
  uart_tx_param #(.DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .CLK_FREQ(1600), .BAUD(100)) u_8e1 (
    .clk(clk), .reset_n(reset_n), .tx_valid(valid_v[1]), .tx_ready(ready_v[1]),
    .tx_data(data[7:0]), .tx(tx_v[1]), .busy(busy_v[1]), .tx_done(done_v[1]));
  uart_tx_param #(.DATA_BITS(8), .PARITY(1), .STOP_BITS(1), .CLK_FREQ(1600), .BAUD(100)) u_8o1 (
    .clk(clk), .reset_n(reset_n), .tx_valid(valid_v[2]), .tx_ready(ready_v[2]),
    .tx_data(data[7:0]), .tx(tx_v[2]), .busy(busy_v[2]), .tx_done(done_v[2]));
  uart_tx_param #(.DATA_BITS(7), .PARITY(0), .STOP_BITS(2), .CLK_FREQ(1600), .BAUD(100)) u_7n2 (
    .clk(clk), .reset_n(reset_n), .tx_valid(valid_v[3]), .tx_ready(ready_v[3]),
    .tx_data(data[6:0]), .tx(tx_v[3]), .busy(busy_v[3]), .tx_done(done_v[3]));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Called at a negedge with the selected unit ready; returns at the negedge of start-bit clock 1.
  task automatic start_frame(input logic [7:0] d, input bit keep);
    check("ready_pre", 32'(ready_v[sel]), 32'd1);
    valid_v[sel] = 1'b1;
    data         = d;
    @(negedge clk);
    if (!keep) valid_v[sel] = 1'b0;
  endtask

  // Compares every clock of a frame against a hand-computed bit string (index 0 = start bit).
  task automatic watch_frame(input string tag, input logic [12:0] exp, input int nbits, input bit poke);
    int len      = nbits * CPB;
    int bad_bits = 0;
    int bad_hs   = 0;
    int done_cnt = 0;
    int done_at  = 0;
    for (int c = 1; c <= len; c++) begin
      if (tx_v[sel] !== exp[(c - 1) / CPB]) bad_bits++;
      if (busy_v[sel] !== 1'b1 || ready_v[sel] !== 1'b0) bad_hs++;
      if (done_v[sel] === 1'b1) begin
        done_cnt++;
        done_at = c;
      end
      if (poke) begin
        valid_v[sel] = 1'($urandom_range(0, 1));
        data         = 8'($urandom);
      end
      if (c < len) @(negedge clk);
    end
    if (poke) valid_v[sel] = 1'b0;
    check({tag, "_bits"}, 32'(bad_bits), 32'd0);
    check({tag, "_busy_ready"}, 32'(bad_hs), 32'd0);
    check({tag, "_done_cnt"}, 32'(done_cnt), 32'd1);
    check({tag, "_done_at"}, 32'(done_at), 32'(len));
  endtask

  task automatic idle_check(input string tag, input int n);
    int bad = 0;
    repeat (n) begin
      @(negedge clk);
      if (tx_v[sel] !== 1'b1 || busy_v[sel] !== 1'b0 || done_v[sel] !== 1'b0) bad++;
    end
    check(tag, 32'(bad), 32'd0);
  endtask

  // Receiver model: samples each bit at its middle clock and rebuilds the frame.
  task automatic rx_frame(input logic [7:0] d);
    int         nb       = nb_cfg[sel];
    int         pm       = par_cfg[sel];
    int         st       = st_cfg[sel];
    int         len      = (1 + nb + ((pm != 0) ? 1 : 0) + st) * CPB;
    int         done_at  = 0;
    int         done_cnt = 0;
    logic [7:0] rxd      = '0;
    logic [7:0] dm;
    logic       rx_start = 1'b1;
    logic       rx_par   = 1'b0;
    logic       stop_bad = 1'b0;
    logic       exp_par;
    dm = d & 8'((1 << nb) - 1);
    for (int c = 1; c <= len; c++) begin
      int b = (c - 1) / CPB;
      if ((c - 1) % CPB == CPB / 2 - 1) begin
        if (b == 0) rx_start = tx_v[sel];
        else if (b <= nb) rxd[b - 1] = tx_v[sel];
        else if (pm != 0 && b == nb + 1) rx_par = tx_v[sel];
        else if (tx_v[sel] !== 1'b1) stop_bad = 1'b1;
      end
      if (done_v[sel] === 1'b1) begin
        done_cnt++;
        done_at = c;
      end
      if (c < len) @(negedge clk);
    end
    exp_par = (pm == 1) ? ~(^dm) : ^dm;
    check("rx_data", 32'(rxd), 32'(dm));
    check("rx_start", 32'(rx_start), 32'd0);
    check("rx_stop", 32'(stop_bad), 32'd0);
    if (pm != 0) check("rx_parity", 32'(rx_par), 32'(exp_par));
    check("rx_done_cnt", 32'(done_cnt), 32'd1);
    check("rx_done_at", 32'(done_at), 32'(len));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    errors++;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    reset_n = 1'b0;
    valid_v = '0;
    data    = '0;
    sel     = 2'd0;
    repeat (3) @(negedge clk);
    check("rst_tx", 32'(tx_v), 32'hF);
    check("rst_busy", 32'(busy_v), 32'h0);
    check("rst_ready", 32'(ready_v), 32'h0);
    check("rst_done", 32'(done_v), 32'h0);
    reset_n = 1'b1;
    @(negedge clk);
    check("ready_after_rst", 32'(ready_v), 32'hF);

    // 8N1 0xA5: 0,1,0,1,0,0,1,0,1,1
    sel = 2'd0;
    start_frame(8'hA5, 1'b0);
    watch_frame("t1_8n1_a5", 13'h034A, 10, 1'b0);
    @(negedge clk);
    check("t1_post_ready", 32'(ready_v[0]), 32'd1);
    check("t1_post_busy", 32'(busy_v[0]), 32'd0);

    // 0x03 with even parity (bit 0), then odd parity (bit 1)
    sel = 2'd1;
    start_frame(8'h03, 1'b0);
    watch_frame("t2_8e1_03", 13'h0406, 11, 1'b0);
    @(negedge clk);
    sel = 2'd2;
    start_frame(8'h03, 1'b0);
    watch_frame("t2_8o1_03", 13'h0606, 11, 1'b0);
    @(negedge clk);

    // 7 data bits, two stop bits, 0x41
    sel = 2'd3;
    start_frame(8'h41, 1'b0);
    watch_frame("t3_7n2_41", 13'h0382, 10, 1'b0);
    @(negedge clk);

    // valid held high: 0x55 then 0xAA back to back; pokes during busy are ignored
    sel = 2'd0;
    start_frame(8'h55, 1'b1);
    data = 8'hAA;
    watch_frame("t4_f1_55", 13'h02AA, 10, 1'b0);
    @(negedge clk);
    check("t4_gap_tx", 32'(tx_v[0]), 32'd1);
    check("t4_gap_ready", 32'(ready_v[0]), 32'd1);
    @(negedge clk);
    valid_v[0] = 1'b0;
    watch_frame("t4_f2_aa", 13'h0354, 10, 1'b1);
    idle_check("t4_no_extra_frame", 40);

    // reset at clock 70 of a frame
    start_frame(8'h00, 1'b0);
    repeat (69) @(negedge clk);
    check("t5_pre_tx", 32'(tx_v[0]), 32'd0);
    reset_n = 1'b0;
    #1;
    check("t5_rst_tx", 32'(tx_v[0]), 32'd1);
    check("t5_rst_busy", 32'(busy_v[0]), 32'd0);
    check("t5_rst_ready", 32'(ready_v[0]), 32'd0);
    check("t5_rst_done", 32'(done_v[0]), 32'd0);
    idle_check("t5_rst_hold", 3);
    reset_n = 1'b1;
    @(negedge clk);
    check("t5_release_ready", 32'(ready_v[0]), 32'd1);
    start_frame(8'h0F, 1'b0);
    watch_frame("t5_f_0f", 13'h021E, 10, 1'b0);
    @(negedge clk);

    // random bytes across all configurations
    for (int i = 0; i < 200; i++) begin
      logic [7:0] d;
      sel = 2'($urandom_range(0, 3));
      d   = 8'($urandom);
      start_frame(d, 1'b0);
      rx_frame(d);
      @(negedge clk);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
